// File: rtl/ring_monitor.sv
// ring_monitor: receive-side checker for a one-hot ring counter.
// Stage 1 registers the incoming word. Stage 2 compares it with the word from
// the previous cycle, decodes its position, tracks lock, counts revolutions
// and records corruption (not one-hot, stall, or wrong step).
`timescale 1ns/1ps
module ring_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8,
  parameter int ERR_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         q_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic                     locked,
  output logic                     rev_tick,
  output logic [REV_W-1:0]         rev_count,
  output logic                     err,
  output logic                     err_flag,
  output logic [ERR_W-1:0]         err_count
);

  localparam int POS_W    = $clog2(WIDTH);
  localparam int STREAK_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  logic [WIDTH-1:0]    s_q, s_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [1:0]          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                pos_valid_q, pos_valid_d;
  logic                locked_q, locked_d;
  logic                rev_tick_q, rev_tick_d;
  logic [REV_W-1:0]    rev_count_q, rev_count_d;
  logic                err_q, err_d;
  logic                err_flag_q, err_flag_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;

  // Expected successor of prev: rotate left by one, MSB wraps to bit 0.
  logic [WIDTH-1:0] prev_rot;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign prev_rot[gi] = prev_q[(gi + WIDTH - 1) % WIDTH];
    end
  endgenerate

  logic                s_onehot;
  logic                prev_onehot;
  logic                good;
  logic [STREAK_W-1:0] streak_inc;
  logic [POS_W-1:0]    pos_enc;

  assign s_onehot    = $onehot(s_q);
  assign prev_onehot = $onehot(prev_q);
  assign good        = s_onehot && prev_onehot && (s_q == prev_rot);
  assign streak_inc  = streak_q + STREAK_W'(1);

  // Binary index of the set bit; only meaningful when s is one-hot.
  always_comb begin
    pos_enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s_q[i]) pos_enc = POS_W'(i);
    end
  end

  // Stage-2 evaluation: lock tracking, revolution counting and error capture.
  always_comb begin
    s_d         = q_in;
    prev_d      = s_q;
    state_d     = state_q;
    streak_d    = streak_q;
    pos_d       = s_onehot ? pos_enc : '0;
    pos_valid_d = s_onehot;
    locked_d    = locked_q;
    rev_tick_d  = 1'b0;
    rev_count_d = rev_count_q;
    err_d       = 1'b0;
    err_flag_d  = clr_err ? 1'b0 : err_flag_q;
    err_count_d = clr_err ? '0 : err_count_q;

    case (state_q)
      ST_HUNT: begin
        locked_d = 1'b0;
        if (good) begin
          if (streak_inc == STREAK_W'(LOCK_CNT)) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            streak_d = '0;
          end else begin
            streak_d = streak_inc;
          end
        end else begin
          streak_d = '0;
        end
      end
      ST_LOCKED: begin
        if (good) begin
          locked_d = 1'b1;
          if (s_q[0]) begin
            rev_tick_d  = 1'b1;
            rev_count_d = rev_count_q + REV_W'(1);
          end
        end else begin
          // A detected error overrides a simultaneous clear.
          state_d    = ST_FAULT;
          locked_d   = 1'b0;
          err_d      = 1'b1;
          err_flag_d = 1'b1;
          if (clr_err)
            err_count_d = ERR_W'(1);
          else if (&err_count_q)
            err_count_d = err_count_q;
          else
            err_count_d = err_count_q + ERR_W'(1);
        end
      end
      ST_FAULT: begin
        // One recovery cycle; the word seen here becomes prev for HUNT.
        state_d  = ST_HUNT;
        streak_d = '0;
        locked_d = 1'b0;
      end
      default: begin
        state_d  = ST_HUNT;
        streak_d = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      prev_q      <= '0;
      state_q     <= ST_HUNT;
      streak_q    <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      rev_tick_q  <= 1'b0;
      rev_count_q <= '0;
      err_q       <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      s_q         <= s_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      streak_q    <= streak_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      locked_q    <= locked_d;
      rev_tick_q  <= rev_tick_d;
      rev_count_q <= rev_count_d;
      err_q       <= err_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign pos       = pos_q;
  assign pos_valid = pos_valid_q;
  assign locked    = locked_q;
  assign rev_tick  = rev_tick_q;
  assign rev_count = rev_count_q;
  assign err       = err_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule
